mem_top_module: RTL and testbench
=================================

# mem_top_module

Parameterised single-port memory controller wrapping an R×C array of N-bit words. Accepts one read or write request per transaction over a simple req/ready handshake and signals completion with a one-cycle `valid` pulse. The flat address is decoded into row and column selects internally. This is the top level of the memory subsystem and connects directly to a bus master.

## Interface
- `R`, default 4: number of rows in the array.
- `C`, default 4: number of columns (words per row).
- `N`, default 4: word width in bits.
- `AW`, derived: address width, equal to $clog2(R*C); this is not a user-overridable parameter.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low. Low resets the block immediately; high is normal operation.
- `cs`  in  1: chip select. Requests are ignored while low.
- `req`  in  1: request strobe. Sampled only while `ready` is 1.
- `rw`  in  1: access type. 0 is write, 1 is read.
- `addr`  in  AW: flat word address; row = addr / C, col = addr % C.
- `Qi`  in  N: write data.
- `Qa`  out  N: read data, registered.
- `valid`  out  1: one-cycle completion pulse, for both reads and writes.
- `ready`  out  1: high when the controller can accept a request.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE:
  - `ready` = 1 whenever `rst` is high.
  - On a rising edge with cs & req & ready = 1, latch `addr`, `rw` and `Qi` into internal registers and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (`ready` = 0):
  - Write: store the latched `Qi` into array[row][col].
  - Read: load `Qa` from array[row][col].
  - Go to DONE.
- DONE:
  - `valid` = 1 and `ready` = 0.
  - Go to IDLE unconditionally.
- Inputs `cs`, `req`, `rw`, `addr` and `Qi` are ignored outside IDLE. A `req` held high across a transaction is not re-sampled until `ready` returns.
- Out-of-range address (addr ≥ R*C, possible when R*C is not a power of 2):
  - A write is dropped and the array is unchanged.
  - A read loads `Qa` = 0.
  - `valid` still pulses.
- `Qa` holds its last read value through writes and idle cycles. It updates only on a read.
- Address decode: the row decoder produces a one-hot row select and the column mux selects the word; decode uses the latched address only.

## Timing
- Reset (`rst` low, asynchronous):
  - state = IDLE, `valid` = 0, `Qa` = 0, all array words = 0, latched registers = 0.
  - `ready` = 0 while `rst` is low.
- Reset asserted mid-transaction: abort immediately. A write in flight does not commit unless the ACCESS edge has already occurred. No `valid` pulse.
- Latency, with edge 0 being the accepting edge:
  - Edge 1 performs the access; read data is on `Qa` after edge 1.
  - `valid` is high from edge 1 to edge 2.
  - `ready` is low from edge 0 to edge 2 and returns high after edge 2.
- Throughput: one transaction per 3 cycles with `req` held high continuously.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- All outputs are registered or derived from state only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset check: hold `rst` = 0 for 25 ns → `Qa` = 0, `valid` = 0, `ready` = 0. Release `rst` → `ready` = 1.
- Write then read, same address: write addr 3 with `Qi` = 0x1, then read addr 3 → `valid` pulses once per transaction and `Qa` = 0x1 in the read's DONE cycle.
- Second location: write addr 5 with `Qi` = 0x6, then read addr 5 → `Qa` = 0x6. Read addr 3 again → still 0x1, showing no aliasing between rows and columns.
- Held `req`: keep `req` = 1 for 6 cycles on a write to addr 7 → exactly 2 transactions are accepted, one every 3 cycles. `valid` pulses 2 times and `ready` goes low during each transaction.
- `cs` low: drive `cs` = 0 with `req` = 1 and a write of 0xF to addr 0 → no state change and `valid` stays 0. A later read of addr 0 returns 0.
- Mid-op reset: assert `rst` low while in ACCESS → `valid` never pulses and `ready` = 0 during reset. After release, `ready` = 1 and a read of any address returns 0.

Source files
------------

// File: rtl/mem_top_module.sv
// Single-port R x C word memory controller with a req/ready handshake.
// A request is accepted in IDLE. ACCESS performs the read or write, and
// DONE pulses valid for one cycle, so a full transaction takes 3 cycles.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cs, req         chip select and request strobe (sampled only in IDLE)
//   rw              0 = write, 1 = read
//   addr            flat word address (row = addr / C, col = addr % C)
//   Qi              write data
//   Qa              registered read data, changes only on a read
//   valid           one-cycle completion pulse
//   ready           high while a request can be accepted
module mem_top_module #(
  parameter int unsigned R = 4,
  parameter int unsigned C = 4,
  parameter int unsigned N = 4,
  localparam int unsigned AW = $clog2(R * C)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          req,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  Qi,
  output logic [N-1:0]  Qa,
  output logic          valid,
  output logic          ready
);

  localparam int unsigned DEPTH = R * C;
  localparam int unsigned RW    = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned CW    = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, next_state;
  logic            capture, do_access;
  logic            ready_d, valid_d;

  logic [AW-1:0]   addr_q;
  logic            rw_q;
  logic [N-1:0]    data_q;

  logic [N-1:0]    mem [R][C];

  logic            in_range;
  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   col_idx;
  logic [R-1:0]    row_sel;
  logic [N-1:0]    rd_word;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and next-output logic
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    do_access  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs && req && ready) begin
          capture    = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        do_access  = 1'b1;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    ready_d = (next_state == IDLE);
    valid_d = (next_state == DONE);
  end

  // Address decode from the latched address: one-hot row select, column index.
  // Out-of-range addresses give an all-zero row select, so writes drop and reads return 0.
  always_comb begin
    in_range = (32'(addr_q) < DEPTH);
    row_idx  = RW'(32'(addr_q) / C);
    col_idx  = CW'(32'(addr_q) % C);
    row_sel  = in_range ? (R'(1) << row_idx) : '0;
  end

  // Column mux over the selected row
  always_comb begin
    rd_word = '0;
    for (int unsigned r = 0; r < R; r++) begin
      if (row_sel[r]) rd_word = mem[RW'(r)][col_idx];
    end
  end

  // Registered outputs, request latches and the array
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready  <= 1'b0;
      valid  <= 1'b0;
      Qa     <= '0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      data_q <= '0;
      for (int unsigned r = 0; r < R; r++) begin
        for (int unsigned c = 0; c < C; c++) begin
          mem[RW'(r)][CW'(c)] <= '0;
        end
      end
    end else begin
      ready <= ready_d;
      valid <= valid_d;
      if (capture) begin
        addr_q <= addr;
        rw_q   <= rw;
        data_q <= Qi;
      end
      if (do_access && rw_q) Qa <= rd_word;
      for (int unsigned r = 0; r < R; r++) begin
        for (int unsigned c = 0; c < C; c++) begin
          if (do_access && !rw_q && row_sel[r] && (col_idx == CW'(c))) begin
            mem[RW'(r)][CW'(c)] <= data_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_top_module.sv
// Randomized self-checking bench for mem_top_module, using a 3 x 4 array so
// that addresses 12..15 are out of range. The reference model is a flat word
// array plus the expected Qa. It predicts results from the handshake rules.
module tb_mem_top_module;

  localparam int unsigned R     = 3;
  localparam int unsigned C     = 4;
  localparam int unsigned N     = 4;
  localparam int unsigned AW    = $clog2(R * C);
  localparam int unsigned DEPTH = R * C;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          req;
  logic          rw;
  logic [AW-1:0] addr;
  logic [N-1:0]  Qi;
  logic [N-1:0]  Qa;
  logic          valid;
  logic          ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] model [DEPTH];
  logic [N-1:0] exp_qa;

  mem_top_module #(.R(R), .C(C), .N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .cs    (cs),
    .req   (req),
    .rw    (rw),
    .addr  (addr),
    .Qi    (Qi),
    .Qa    (Qa),
    .valid (valid),
    .ready (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_qa = '0;
  endtask

  // One request, checked through its full accept / access / done sequence
  task automatic txn(input logic t_cs, input logic t_rw, input logic [AW-1:0] t_addr,
                     input logic [N-1:0] t_data);
    int waitc;
    @(negedge clk);
    cs = t_cs; req = 1'b1; rw = t_rw; addr = t_addr; Qi = t_data;
    if (!t_cs) begin
      @(negedge clk);
      check("cs_low_valid", 32'(valid), 32'd0);
      check("cs_low_ready", 32'(ready), 32'd1);
      req = 1'b0; cs = 1'b1;
      return;
    end
    waitc = 0;
    while (!ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'd1);
      req = 1'b0;
      return;
    end
    if (t_rw) exp_qa = (32'(t_addr) < DEPTH) ? model[t_addr] : '0;
    else if (32'(t_addr) < DEPTH) model[t_addr] = t_data;
    @(negedge clk);
    check("acc_ready", 32'(ready), 32'd0);
    check("acc_valid", 32'(valid), 32'd0);
    // Inputs are ignored outside IDLE, so scramble them here
    req = 1'b0; rw = 1'($urandom); addr = AW'($urandom); Qi = N'($urandom);
    @(negedge clk);
    check("done_valid", 32'(valid), 32'd1);
    check("done_ready", 32'(ready), 32'd0);
    check("done_qa", 32'(Qa), 32'(exp_qa));
    @(negedge clk);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    int vcnt, rlow;
    logic [N-1:0] d;
    cs = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; Qi = '0;
    model_clear();

    // Reset
    rst = 1'b0;
    #23;
    check("rst_qa", 32'(Qa), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);

    // Directed write/read pairs
    txn(1'b1, 1'b0, AW'(3), N'(4'h1));
    txn(1'b1, 1'b1, AW'(3), '0);
    txn(1'b1, 1'b0, AW'(5), N'(4'h6));
    txn(1'b1, 1'b1, AW'(5), '0);
    txn(1'b1, 1'b1, AW'(3), '0);

    // Held req across 6 cycles: 2 accepted writes to addr 7
    d = N'(4'h9);
    @(negedge clk);
    cs = 1'b1; req = 1'b1; rw = 1'b0; addr = AW'(7); Qi = d;
    vcnt = 0; rlow = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid) vcnt++;
      if (!ready) rlow++;
    end
    req = 1'b0;
    model[7] = d;
    check("held_valid_pulses", 32'(vcnt), 32'd2);
    check("held_ready_low", 32'(rlow), 32'd4);
    txn(1'b1, 1'b1, AW'(7), '0);

    // Chip select low: request ignored
    txn(1'b0, 1'b0, AW'(0), N'(4'hF));
    txn(1'b1, 1'b1, AW'(0), '0);

    // Out-of-range write dropped, read returns 0
    txn(1'b1, 1'b0, AW'(13), N'(4'hA));
    txn(1'b1, 1'b1, AW'(5), '0);
    txn(1'b1, 1'b1, AW'(13), '0);

    // Reset while in ACCESS aborts the write
    @(negedge clk);
    cs = 1'b1; req = 1'b1; rw = 1'b0; addr = AW'(9); Qi = N'(4'hC);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_qa", 32'(Qa), 32'd0);
    model_clear();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_hold_valid", 32'(valid), 32'd0);
      check("midrst_hold_ready", 32'(ready), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", 32'(ready), 32'd1);
    txn(1'b1, 1'b1, AW'(9), '0);
    txn(1'b1, 1'b1, AW'(5), '0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      txn(($urandom_range(0, 4) != 0), 1'($urandom), AW'($urandom_range(0, 15)), N'($urandom));
    end

    // Read back every location
    for (int a = 0; a < 16; a++) txn(1'b1, 1'b1, AW'(a), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
